// File: rtl/ft_lsu_lockstep_checker_if.sv
// Lockstep LSU bus bundle: two core request ports, the shared core response and the memory side.
// The slave modport is the checker's view; master is the view of whoever drives cores and memory.
interface ft_lsu_lockstep_checker_if;
  logic        a_data_req_i;
  logic        a_data_we_i;
  logic [3:0]  a_data_be_i;
  logic [31:0] a_data_addr_i;
  logic [31:0] a_data_wdata_i;

  logic        b_data_req_i;
  logic        b_data_we_i;
  logic [3:0]  b_data_be_i;
  logic [31:0] b_data_addr_i;
  logic [31:0] b_data_wdata_i;

  logic        core_data_gnt_o;
  logic        core_data_rvalid_o;
  logic        core_data_err_o;
  logic [31:0] core_data_rdata_o;

  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic        data_err_i;
  logic [31:0] data_rdata_i;

  modport slave (
    input  a_data_req_i, a_data_we_i, a_data_be_i, a_data_addr_i, a_data_wdata_i,
    input  b_data_req_i, b_data_we_i, b_data_be_i, b_data_addr_i, b_data_wdata_i,
    output core_data_gnt_o, core_data_rvalid_o, core_data_err_o, core_data_rdata_o,
    output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    input  data_gnt_i, data_rvalid_i, data_err_i, data_rdata_i
  );

  modport master (
    output a_data_req_i, a_data_we_i, a_data_be_i, a_data_addr_i, a_data_wdata_i,
    output b_data_req_i, b_data_we_i, b_data_be_i, b_data_addr_i, b_data_wdata_i,
    input  core_data_gnt_o, core_data_rvalid_o, core_data_err_o, core_data_rdata_o,
    input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    output data_gnt_i, data_rvalid_i, data_err_i, data_rdata_i
  );
endinterface

// File: rtl/ft_lsu_lockstep_checker.sv
// Compares the LSU requests of two lockstepped cores and forwards core 0's request to memory
// (one outstanding transaction, 1-cycle request latency, zero-latency response, WAIT_RV timeout).
module ft_lsu_lockstep_checker #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter bit          CHECK_WDATA    = 1'b1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  ft_lsu_lockstep_checker_if.slave        bus,
  input  logic                            enable_i,
  input  logic                            clear_i,
  output logic                            mismatch_o,
  output logic                            fault_o,
  output logic                            timeout_o,
  output logic [7:0]                      mismatch_cnt_o,
  output logic                            busy_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_WAIT_RV = 2'd2,
    S_FAULT   = 2'd3
  } state_e;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mismatch_q, mismatch_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        any_req, wdata_ok, compare_ok;

  logic        req_c, we_c, gnt_c, rvalid_c, err_c;
  logic [3:0]  be_c;
  logic [31:0] addr_c, wdata_c, rdata_c;

  assign any_req  = bus.a_data_req_i | bus.b_data_req_i;
  assign wdata_ok = !(CHECK_WDATA && bus.a_data_we_i && bus.b_data_we_i) ||
                    (bus.a_data_wdata_i == bus.b_data_wdata_i);
  assign compare_ok = (bus.a_data_req_i == bus.b_data_req_i) &&
                      (bus.a_data_we_i  == bus.b_data_we_i)  &&
                      (bus.a_data_be_i  == bus.b_data_be_i)  &&
                      (bus.a_data_addr_i == bus.b_data_addr_i) &&
                      wdata_ok;

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    cnt_d      = cnt_q;
    mismatch_d = 1'b0;
    we_d       = we_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    req_c      = 1'b0;
    we_c       = 1'b0;
    be_c       = 4'h0;
    addr_c     = 32'h0;
    wdata_c    = 32'h0;
    gnt_c      = 1'b0;
    rvalid_c   = 1'b0;
    err_c      = 1'b0;
    rdata_c    = 32'h0;
    timeout_o  = 1'b0;
    busy_o     = 1'b0;
    fault_o    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (any_req && enable_i && !compare_ok) begin
          state_d    = S_FAULT;
          mismatch_d = 1'b1;
          cnt_d      = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end else if (bus.a_data_req_i) begin
          state_d = S_REQ;
          we_d    = bus.a_data_we_i;
          be_d    = bus.a_data_be_i;
          addr_d  = bus.a_data_addr_i;
          wdata_d = bus.a_data_wdata_i;
        end
      end

      S_REQ: begin
        busy_o  = 1'b1;
        req_c   = 1'b1;
        we_c    = we_q;
        be_c    = be_q;
        addr_c  = addr_q;
        wdata_c = wdata_q;
        gnt_c   = bus.data_gnt_i;
        if (bus.data_gnt_i) begin
          state_d = S_WAIT_RV;
          wait_d  = 8'd0;
        end
      end

      S_WAIT_RV: begin
        busy_o   = 1'b1;
        rvalid_c = bus.data_rvalid_i;
        err_c    = bus.data_err_i;
        rdata_c  = bus.data_rdata_i;
        if (bus.data_rvalid_i) begin
          state_d = S_IDLE;
        end else if (wait_q == WAIT_LAST) begin
          // Synthesised error response so the cores never stall on a lost reply.
          rvalid_c  = 1'b1;
          err_c     = 1'b1;
          rdata_c   = 32'h0;
          timeout_o = 1'b1;
          state_d   = S_IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      S_FAULT: begin
        fault_o = 1'b1;
        if (clear_i) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      wait_q     <= 8'd0;
      cnt_q      <= 8'd0;
      mismatch_q <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= 4'h0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      cnt_q      <= cnt_d;
      mismatch_q <= mismatch_d;
      we_q       <= we_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign bus.data_req_o         = req_c;
  assign bus.data_we_o          = we_c;
  assign bus.data_be_o          = be_c;
  assign bus.data_addr_o        = addr_c;
  assign bus.data_wdata_o       = wdata_c;
  assign bus.core_data_gnt_o    = gnt_c;
  assign bus.core_data_rvalid_o = rvalid_c;
  assign bus.core_data_err_o    = err_c;
  assign bus.core_data_rdata_o  = rdata_c;

  assign mismatch_o     = mismatch_q;
  assign mismatch_cnt_o = cnt_q;

endmodule

// File: tb/tb_ft_lsu_lockstep_checker.sv
// Bench for ft_lsu_lockstep_checker: per-cycle vector table plus request/response scoreboards.
// dut0 uses TIMEOUT_CYCLES=4 with wdata compare; dut1 shares its stimulus with wdata compare off.
module tb_ft_lsu_lockstep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, clr;
  logic       mm0, flt0, to0, busy0;
  logic [7:0] cnt0;
  logic       mm1, flt1, to1, busy1;
  logic [7:0] cnt1;

  ft_lsu_lockstep_checker_if bus0 ();
  ft_lsu_lockstep_checker_if bus1 ();

  ft_lsu_lockstep_checker #(.TIMEOUT_CYCLES(4), .CHECK_WDATA(1'b1)) dut0 (
    .clk_i(clk), .rst_i(rst), .bus(bus0), .enable_i(en), .clear_i(clr),
    .mismatch_o(mm0), .fault_o(flt0), .timeout_o(to0), .mismatch_cnt_o(cnt0), .busy_o(busy0)
  );

  ft_lsu_lockstep_checker #(.TIMEOUT_CYCLES(64), .CHECK_WDATA(1'b0)) dut1 (
    .clk_i(clk), .rst_i(rst), .bus(bus1), .enable_i(en), .clear_i(clr),
    .mismatch_o(mm1), .fault_o(flt1), .timeout_o(to1), .mismatch_cnt_o(cnt1), .busy_o(busy1)
  );

  assign bus1.a_data_req_i   = bus0.a_data_req_i;
  assign bus1.a_data_we_i    = bus0.a_data_we_i;
  assign bus1.a_data_be_i    = bus0.a_data_be_i;
  assign bus1.a_data_addr_i  = bus0.a_data_addr_i;
  assign bus1.a_data_wdata_i = bus0.a_data_wdata_i;
  assign bus1.b_data_req_i   = bus0.b_data_req_i;
  assign bus1.b_data_we_i    = bus0.b_data_we_i;
  assign bus1.b_data_be_i    = bus0.b_data_be_i;
  assign bus1.b_data_addr_i  = bus0.b_data_addr_i;
  assign bus1.b_data_wdata_i = bus0.b_data_wdata_i;
  assign bus1.data_gnt_i     = bus0.data_gnt_i;
  assign bus1.data_rvalid_i  = bus0.data_rvalid_i;
  assign bus1.data_err_i     = bus0.data_err_i;
  assign bus1.data_rdata_i   = bus0.data_rdata_i;

  // s = {rst, ra rb we, en clr, gnt rv err}; e = {req cgnt, crv err, mm flt, to busy}
  typedef struct {
    logic [8:0]  s;
    logic [7:0]  e;
    bit          acc;
    logic [31:0] aa, ab, wa, wb, rd;
  } vec_t;

  vec_t        tbl[$];
  logic [68:0] req_q[$];
  logic [31:0] rsp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          row_id = 0;
  logic [7:0]  exp_cnt = 8'd0;

  function automatic vec_t V(logic [8:0] s, logic [7:0] e, bit acc,
                             logic [31:0] aa, logic [31:0] ab,
                             logic [31:0] wa, logic [31:0] wb, logic [31:0] rd);
    vec_t v;
    v.s = s; v.e = e; v.acc = acc;
    v.aa = aa; v.ab = ab; v.wa = wa; v.wb = wb; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    logic [68:0] ri;
    logic [31:0] rr;
    rst                   = v.s[8];
    bus0.a_data_req_i     = v.s[7];
    bus0.b_data_req_i     = v.s[6];
    bus0.a_data_we_i      = v.s[5];
    bus0.b_data_we_i      = v.s[5];
    bus0.a_data_be_i      = v.s[5] ? 4'b0011 : 4'b1111;
    bus0.b_data_be_i      = v.s[5] ? 4'b0011 : 4'b1111;
    en                    = v.s[4];
    clr                   = v.s[3];
    bus0.data_gnt_i       = v.s[2];
    bus0.data_rvalid_i    = v.s[1];
    bus0.data_err_i       = v.s[0];
    bus0.a_data_addr_i    = v.aa;
    bus0.b_data_addr_i    = v.ab;
    bus0.a_data_wdata_i   = v.wa;
    bus0.b_data_wdata_i   = v.wb;
    bus0.data_rdata_i     = v.rd;
    if (v.acc) req_q.push_back({v.s[5], (v.s[5] ? 4'b0011 : 4'b1111), v.aa, v.wa});
    if (v.e[5]) rsp_q.push_back(v.e[1] ? 32'h0 : v.rd);
    if (v.e[3]) exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'd1;

    @(negedge clk);
    chk($sformatf("row%0d_flags", row_id),
        {bus0.data_req_o, bus0.core_data_gnt_o, bus0.core_data_rvalid_o, bus0.core_data_err_o,
         mm0, flt0, to0, busy0}, v.e);
    chk($sformatf("row%0d_cnt", row_id), cnt0, exp_cnt);
    if (!v.e[7])
      chk($sformatf("row%0d_membus_idle", row_id),
          {bus0.data_we_o, bus0.data_be_o, bus0.data_addr_o, bus0.data_wdata_o}, 0);
    if (!v.e[5])
      chk($sformatf("row%0d_rdata_idle", row_id), bus0.core_data_rdata_o, 0);
    if (bus0.data_req_o && bus0.data_gnt_i) begin
      chk($sformatf("row%0d_req_expected", row_id), req_q.size() != 0, 1);
      if (req_q.size() != 0) begin
        ri = req_q.pop_front();
        chk($sformatf("row%0d_req_fields", row_id),
            {bus0.data_we_o, bus0.data_be_o, bus0.data_addr_o, bus0.data_wdata_o}, ri);
      end
    end
    if (bus0.core_data_rvalid_o) begin
      chk($sformatf("row%0d_rsp_expected", row_id), rsp_q.size() != 0, 1);
      if (rsp_q.size() != 0) begin
        rr = rsp_q.pop_front();
        chk($sformatf("row%0d_rsp_rdata", row_id), bus0.core_data_rdata_o, rr);
      end
    end
    // dut1 ignores wdata, so the 0x11/0x12 store must go out to memory
    if (row_id == 8) begin
      chk("nowdata_store_req", {bus1.data_req_o, bus1.data_we_o, flt1, mm1}, 4'b1100);
      chk("nowdata_store_wdata", bus1.data_wdata_o, 32'h11);
    end
    if (row_id == 9) chk("nowdata_store_gnt", bus1.core_data_gnt_o, 1'b1);

    @(posedge clk);
    #1;
    if (v.s[8]) exp_cnt = 8'd0;
    row_id++;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0;
    bus0.a_data_req_i = 1'b0; bus0.a_data_we_i = 1'b0; bus0.a_data_be_i = 4'h0;
    bus0.a_data_addr_i = 32'h0; bus0.a_data_wdata_i = 32'h0;
    bus0.b_data_req_i = 1'b0; bus0.b_data_we_i = 1'b0; bus0.b_data_be_i = 4'h0;
    bus0.b_data_addr_i = 32'h0; bus0.b_data_wdata_i = 32'h0;
    bus0.data_gnt_i = 1'b0; bus0.data_rvalid_i = 1'b0; bus0.data_err_i = 1'b0;
    bus0.data_rdata_i = 32'h0;

    // reset state
    tbl.push_back(V(9'b1_000_10_000, 8'b00_00_00_00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(9'b0_000_10_000, 8'b00_00_00_00, 0, 0, 0, 0, 0, 0));
    // matched load 0x100; rvalid while in REQ is ignored, junk core fields in REQ ignored
    tbl.push_back(V(9'b0_110_10_000, 8'b00_00_00_00, 1, 32'h100, 32'h100, 0, 0, 0));
    tbl.push_back(V(9'b0_000_10_010, 8'b10_00_00_01, 0, 32'h555, 32'h777, 0, 0, 32'h42));
    tbl.push_back(V(9'b0_000_10_100, 8'b11_00_00_01, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(9'b0_000_10_010, 8'b00_10_00_01, 0, 0, 0, 0, 0, 32'hDEADBEEF));
    tbl.push_back(V(9'b0_000_10_000, 8'b00_00_00_00, 0, 0, 0, 0, 0, 0));
    // store wdata mismatch -> FAULT, nothing forwarded, then clear
    tbl.push_back(V(9'b0_111_10_000, 8'b00_00_00_00, 0, 32'h200, 32'h200, 32'h11, 32'h12, 0));
    tbl.push_back(V(9'b0_000_10_000, 8'b00_00_11_00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(9'b0_000_10_110, 8'b00_00_01_00, 0, 0, 0, 0, 0, 32'h99));
    tbl.push_back(V(9'b0_000_11_000, 8'b00_00_01_00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(9'b0_000_10_000, 8'b00_00_00_00, 0, 0, 0, 0, 0, 0));
    // core 0 alone with enable off is forwarded; enable toggled mid-flight; error response
    tbl.push_back(V(9'b0_101_00_000, 8'b00_00_00_00, 1, 32'h300, 0, 32'hCAFE, 0, 0));
    tbl.push_back(V(9'b0_000_00_100, 8'b11_00_00_01, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(9'b0_000_10_011, 8'b00_11_00_01, 0, 0, 0, 0, 0, 32'h1234));
    // core 0 alone with enable on faults
    tbl.push_back(V(9'b0_100_10_000, 8'b00_00_00_00, 0, 32'h300, 0, 0, 0, 0));
    tbl.push_back(V(9'b0_000_10_000, 8'b00_00_11_00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(9'b0_000_11_000, 8'b00_00_01_00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(9'b0_000_10_000, 8'b00_00_00_00, 0, 0, 0, 0, 0, 0));
    // address mismatch, cleared in the first FAULT cycle
    tbl.push_back(V(9'b0_110_10_000, 8'b00_00_00_00, 0, 32'h400, 32'h404, 0, 0, 0));
    tbl.push_back(V(9'b0_000_11_000, 8'b00_00_11_00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(9'b0_000_10_000, 8'b00_00_00_00, 0, 0, 0, 0, 0, 0));
    // enable off hides a core 1 address mismatch; then timeout on the 4th WAIT_RV cycle
    tbl.push_back(V(9'b0_110_00_000, 8'b00_00_00_00, 1, 32'h500, 32'h504, 0, 0, 0));
    tbl.push_back(V(9'b0_000_00_000, 8'b10_00_00_01, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(9'b0_000_00_100, 8'b11_00_00_01, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(V(9'b0_000_10_000, 8'b00_00_00_01, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(9'b0_000_10_000, 8'b00_11_00_11, 0, 0, 0, 0, 0, 32'h77));
    tbl.push_back(V(9'b0_000_10_010, 8'b00_00_00_00, 0, 0, 0, 0, 0, 32'hBAD));
    tbl.push_back(V(9'b0_000_10_000, 8'b00_00_00_00, 0, 0, 0, 0, 0, 0));
    // rvalid on the last allowed WAIT_RV cycle is a normal response
    tbl.push_back(V(9'b0_110_10_000, 8'b00_00_00_00, 1, 32'h600, 32'h600, 0, 0, 0));
    tbl.push_back(V(9'b0_000_10_100, 8'b11_00_00_01, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(V(9'b0_000_10_000, 8'b00_00_00_01, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(9'b0_000_10_010, 8'b00_10_00_01, 0, 0, 0, 0, 0, 32'h600D));
    tbl.push_back(V(9'b0_000_10_000, 8'b00_00_00_00, 0, 0, 0, 0, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    foreach (tbl[i]) apply(tbl[i]);

    // 256 cleared mismatches: counter saturates at 255
    for (int k = 0; k < 256; k++) begin
      apply(V(9'b0_100_10_000, 8'b00_00_00_00, 0, 32'h800, 0, 0, 0, 0));
      apply(V(9'b0_000_11_000, 8'b00_00_11_00, 0, 0, 0, 0, 0, 0));
    end
    apply(V(9'b0_000_10_000, 8'b00_00_00_00, 0, 0, 0, 0, 0, 0));
    chk("cnt_saturated", cnt0, 8'hFF);

    // reset while in WAIT_RV drops the response and clears the counter
    apply(V(9'b0_110_10_000, 8'b00_00_00_00, 1, 32'h700, 32'h700, 0, 0, 0));
    apply(V(9'b0_000_10_100, 8'b11_00_00_01, 0, 0, 0, 0, 0, 0));
    apply(V(9'b0_000_10_000, 8'b00_00_00_01, 0, 0, 0, 0, 0, 0));
    apply(V(9'b1_000_10_000, 8'b00_00_00_01, 0, 0, 0, 0, 0, 0));
    apply(V(9'b0_000_10_010, 8'b00_00_00_00, 0, 0, 0, 0, 0, 32'hF00));
    chk("dut1_after_reset", {busy1, flt1, cnt1}, 10'h0);
    apply(V(9'b0_000_10_000, 8'b00_00_00_00, 0, 0, 0, 0, 0, 0));

    chk("req_q_drained", req_q.size(), 0);
    chk("rsp_q_drained", rsp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ft_lsu_lockstep_checker.md
FT_LSU_LOCKSTEP_CHECKER -- requirements
Module: ft_lsu_lockstep_checker

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, max cycles WAIT_RV waits for data_rvalid_i (legal range 2..255).
REQ-002 SHALL have parameter CHECK_WDATA, default 1; 1 = include wdata in the compare on stores.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk_i  in  1  clock; rst_i  in  1  sync active-high reset.
REQ-004 SHALL have ports a_data_req_i, a_data_we_i  in  1  each, core 0 request and write enable; a_data_be_i  in  4  core 0 byte enables; a_data_addr_i, a_data_wdata_i  in  32 each, core 0 address and write data.
REQ-005 SHALL have ports b_data_req_i, b_data_we_i, b_data_be_i, b_data_addr_i, b_data_wdata_i, core 1 copies of REQ-004, same widths.
REQ-006 SHALL have ports core_data_gnt_o, core_data_rvalid_o, core_data_err_o  out  1  each; core_data_rdata_o  out  32. All four are shared by both cores.
REQ-007 SHALL have ports data_req_o, data_we_o  out  1; data_be_o  out  4; data_addr_o, data_wdata_o  out  32; data_gnt_i, data_rvalid_i, data_err_i  in  1; data_rdata_i  in  32. These form the memory side.
REQ-008 SHALL have ports enable_i  in  1  compare enable; clear_i  in  1  leave FAULT; mismatch_o  out  1  one-cycle pulse; fault_o  out  1  in FAULT; timeout_o  out  1  one-cycle pulse; mismatch_cnt_o  out  8  saturating count; busy_o  out  1  transaction outstanding.

Function
REQ-009 SHALL implement FSM states IDLE, REQ, WAIT_RV, FAULT. Single outstanding transaction only.
REQ-010 IDLE, any req: compare_ok is true when a_req==b_req, we, be and addr are equal, and wdata is equal when CHECK_WDATA and we are both set.
REQ-011 IDLE, a_req=1 with (compare_ok or enable_i=0): SHALL register core 0's we/be/addr/wdata and go to REQ. Core 1 fields are ignored when enable_i=0.
REQ-012 IDLE, any req with !compare_ok and enable_i=1: SHALL go to FAULT, pulse mismatch_o, and increment mismatch_cnt_o, saturating at 255. No memory request is issued.
REQ-013 REQ: data_req_o=1 carrying the registered fields; core_data_gnt_o=data_gnt_i (combinational); on data_gnt_i go to WAIT_RV. Core reqs are not re-compared in this state.
REQ-014 WAIT_RV: core_data_rvalid_o/rdata/err=data_rvalid_i/data_rdata_i/data_err_i (combinational); on data_rvalid_i go to IDLE.
REQ-015 WAIT_RV: a wait counter SHALL start at 0 on entry. If it reaches TIMEOUT_CYCLES-1 with no rvalid: core_data_rvalid_o=1, core_data_err_o=1, rdata=0, pulse timeout_o, go to IDLE. A late data_rvalid_i in IDLE SHALL be ignored.
REQ-016 Latency: core req in cycle N gives data_req_o in N+1 at the earliest; response passes through with 0 cycles added.
REQ-017 data_rvalid_i in REQ or IDLE SHALL be ignored.
REQ-018 FAULT: no memory request, no gnt or rvalid to the cores, fault_o=1. clear_i=1 goes to IDLE next cycle; mismatch_cnt_o is kept.
REQ-019 Outside REQ, data_req_o=0 and data_we_o/be/addr/wdata=0. Outside WAIT_RV, core_data_rvalid_o/err/rdata=0 except on timeout (REQ-015).
REQ-020 busy_o=1 in REQ and WAIT_RV.
REQ-021 enable_i is sampled only in IDLE; changing it mid-transaction has no effect on that transaction.

Reset
REQ-022 rst_i SHALL give next cycle: state IDLE, all outputs 0, mismatch_cnt_o=0, wait counter 0, registered fields 0.
REQ-023 rst_i SHALL take priority over every input, including in REQ/WAIT_RV. An in-flight response is dropped; data_req_o=0 the cycle after reset is sampled.

Verification
REQ-024 Matched load, both reqs addr 0x100: data_req_o=1 in N+1, gnt in N+2, rvalid in N+3 with rdata 0xDEADBEEF -> core_data_rvalid_o=1, rdata 0xDEADBEEF, mismatch_cnt_o=0.
REQ-025 Store with wdata 0x11 vs 0x12, enable_i=1 -> mismatch_o pulse, fault_o=1, data_req_o never 1. Then clear_i -> IDLE, count=1. Same stimulus with CHECK_WDATA=0 -> the store proceeds.
REQ-026 Only a_req=1, enable_i=0 -> forwarded normally. Same with enable_i=1 -> FAULT.
REQ-027 Grant, then no rvalid, TIMEOUT_CYCLES=4 -> cycle 4 of WAIT_RV shows core_data_rvalid_o=1, err=1, timeout_o pulse. A late rvalid is ignored.
REQ-028 256 mismatches, each cleared -> mismatch_cnt_o stays 255. rst_i asserted in WAIT_RV -> all outputs 0 next cycle and count 0.
